// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CKSUM_EN selects whether images carry a trailing checksum byte.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [15:0] len_t;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CKSUM,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_word_asm.sv
// Shift-in byte-to-word assembler: MSB arrives first, and a registered
// word_valid_o pulse follows the transfer of the last byte of each word.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        byte_en_i,
    input  logic [7:0]                  byte_i,
    output logic [1:0]                  cnt_o,
    output logic [8*WORD_BYTES-1:0]     word_o,
    output logic                        word_valid_o
);

    logic [1:0]              cnt_q;
    logic [8*WORD_BYTES-1:0] word_q;
    logic                    valid_q;

    // NOTE: non-blocking (<=) for every flop so all registers see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                cnt_q <= '0;
            end else if (byte_en_i) begin
                word_q  <= {word_q[8*WORD_BYTES-9:0], byte_i};
                cnt_q   <= cnt_q + 2'd1;
                valid_q <= (cnt_q == 2'(WORD_BYTES - 1));
            end
        end
    end

    assign cnt_o        = cnt_q;
    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte image and writes it to instruction
// memory while holding the CPU in reset. IMEM_LOADER_CKSUM_EN enables the checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        restart_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [31:0] MAX_W = MAX_WORDS;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_e END_ST = ST_CKSUM;
`else
    localparam state_e END_ST = ST_DONE;
`endif

    state_e      state_q, state_d;
    logic        run_q;
    logic [31:0] addr_q;
    len_t        len_q;
    len_t        word_cnt_q;

    logic        xfer;
    logic        word_end;
    logic        last_word;
    len_t        len_n;
    logic [1:0]  asm_cnt;
    logic [31:0] asm_word;
    logic        asm_valid;

    // Ready stays low until the first edge after reset release.
    assign byte_ready_o = run_q && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign xfer         = byte_valid_i && byte_ready_o && !restart_i;
    assign len_n        = {len_q[15:8], byte_i};
    assign word_end     = xfer && (state_q == ST_DATA) && (asm_cnt == 2'(WORD_BYTES - 1));
    assign last_word    = (word_cnt_q + len_t'(1)) == len_q;

    imem_word_asm u_word_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (restart_i),
        .byte_en_i    (xfer && (state_q == ST_DATA)),
        .byte_i       (byte_i),
        .cnt_o        (asm_cnt),
        .word_o       (asm_word),
        .word_valid_o (asm_valid)
    );

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] cksum_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cksum_q <= '0;
        end else if (restart_i) begin
            cksum_q <= '0;
        end else if (xfer && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA})) begin
            cksum_q <= cksum_q ^ byte_i;
        end
    end
`endif

    // NOTE: state_d gets its default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (restart_i) begin
            state_d = ST_LEN_HI;
        end else if (xfer) begin
            case (state_q)
                ST_LEN_HI: state_d = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (32'(len_n) > MAX_W)  state_d = ST_ERR;
                    else if (len_n == '0)    state_d = END_ST;
                    else                     state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (word_end && last_word) state_d = END_ST;
                end
`ifdef IMEM_LOADER_CKSUM_EN
                ST_CKSUM: state_d = (byte_i == cksum_q) ? ST_DONE : ST_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // A write pulse already on the bus finishes even if restart lands with it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q      <= 1'b0;
            addr_q     <= BASE_ADDR;
            len_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (restart_i) begin
                addr_q     <= BASE_ADDR;
                len_q      <= '0;
                word_cnt_q <= '0;
            end else begin
                if (asm_valid)                         addr_q     <= addr_q + 32'(WORD_BYTES);
                if (xfer && (state_q == ST_LEN_HI))    len_q      <= {byte_i, 8'h00};
                if (xfer && (state_q == ST_LEN_LO))    len_q      <= len_n;
                if (word_end)                          word_cnt_q <= word_cnt_q + len_t'(1);
            end
        end
    end

    assign mem_we_o    = asm_valid;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = asm_word;
    assign cpu_hold_o  = (state_q != ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios with random payloads,
// compared against a queue-based image/write model.
module tb_imem_loader;

    localparam int          MAX_WORDS = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        restart_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  img_q[$];
    logic [31:0] words_q[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    bit          exp_done;
    bit          exp_err;
    logic        prev_we = 1'b0;
    int          wide_cnt = 0;

    imem_loader #(
        .MAX_WORDS (MAX_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .restart_i    (restart_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // Write monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk_i) begin
        if (mem_we_o === 1'b1) begin
            wr_a.push_back(mem_addr_o);
            wr_d.push_back(mem_wdata_o);
            if (prev_we === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        prev_we <= mem_we_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom());
    endtask

    // Reference model: the byte image and the writes it must produce.
    task automatic make_image(input logic [15:0] n, input bit bad_ck);
        logic [7:0] ck;
        img_q.delete();
        exp_a.delete();
        exp_d.delete();
        img_q.push_back(n[15:8]);
        img_q.push_back(n[7:0]);
        ck = n[15:8] ^ n[7:0];
        if (int'(n) > MAX_WORDS) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            exp_a.push_back(BASE_ADDR + 32'(4 * i));
            exp_d.push_back(words_q[i]);
            for (int k = 3; k >= 0; k--) begin
                img_q.push_back(words_q[i][8*k +: 8]);
                ck ^= words_q[i][8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        img_q.push_back(ck ^ {7'b0, bad_ck});
        exp_err = bad_ck;
`else
        exp_err = 1'b0;
`endif
        exp_done = !exp_err;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        bit sent  = 1'b0;
        while (!sent) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                byte_valid_i = 1'b0;
            end else begin
                byte_valid_i = 1'b1;
                byte_i       = b;
            end
            sent = byte_valid_i && byte_ready_o;
            @(posedge clk_i);
            #1;
            guard++;
            if (!sent && guard > 64) begin
                check("byte_accept", 32'(byte_ready_o), 32'd1);
                break;
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic do_restart();
        restart_i = 1'b1;
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        check("restart_ready", 32'(byte_ready_o), 32'd1);
        check("restart_flags", {30'b0, done_o, err_o}, 32'd0);
    endtask

    task automatic run_load(input bit gaps, input string tag);
        int base = wr_a.size();
        foreach (img_q[i]) send_byte(img_q[i], gaps);
        repeat (3) @(posedge clk_i);
        #1;
        check({tag, "_nwr"}, 32'(wr_a.size() - base), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && base + i < wr_a.size(); i++) begin
            check({tag, "_addr"}, wr_a[base+i], exp_a[i]);
            check({tag, "_data"}, wr_d[base+i], exp_d[i]);
        end
        check({tag, "_done"},  32'(done_o),       32'(exp_done));
        check({tag, "_err"},   32'(err_o),        32'(exp_err));
        check({tag, "_hold"},  32'(cpu_hold_o),   32'(!exp_done));
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    endtask

    initial begin
        int base;
        rst_i        = 1'b0;
        restart_i    = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_we",    32'(mem_we_o),     32'd0);
        check("rst_addr",  mem_addr_o,        BASE_ADDR);
        check("rst_wdata", mem_wdata_o,       32'd0);
        check("rst_hold",  32'(cpu_hold_o),   32'd1);
        check("rst_done",  32'(done_o),       32'd0);
        check("rst_err",   32'(err_o),        32'd0);
        rst_i = 1'b1;
        #1;
        check("rel_ready_pre", 32'(byte_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("rel_ready_post", 32'(byte_ready_o), 32'd1);

        // Reference two-word image.
        words_q.delete();
        words_q.push_back(32'h12345678);
        words_q.push_back(32'h9ABCDEF0);
        make_image(16'd2, 1'b0);
        run_load(1'b0, "n2");
        do_restart();

`ifdef IMEM_LOADER_CKSUM_EN
        make_image(16'd2, 1'b1);
        run_load(1'b0, "badck");
        do_restart();
`endif

        // Oversized length fails right after the second byte.
        make_image(16'h0101, 1'b0);
        base = wr_a.size();
        send_byte(img_q[0], 1'b0);
        send_byte(img_q[1], 1'b0);
        check("oversize_err_now", 32'(err_o), 32'd1);
        check("oversize_ready",   32'(byte_ready_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("oversize_nwr",  32'(wr_a.size() - base), 32'd0);
        check("oversize_hold", 32'(cpu_hold_o), 32'd1);
        do_restart();

        // Zero-length and maximum-length images.
        fill_words(0);
        make_image(16'd0, 1'b0);
        run_load(1'b0, "n0");
        do_restart();

        fill_words(MAX_WORDS);
        make_image(16'(MAX_WORDS), 1'b0);
        run_load(1'b0, "nmax");
        do_restart();

        // Random valid gaps during a four-word load.
        fill_words(4);
        make_image(16'd4, 1'b0);
        run_load(1'b1, "gaps");
        check("we_width", 32'(wide_cnt), 32'd0);
        do_restart();

        // Reset in the middle of the second word.
        fill_words(3);
        make_image(16'd3, 1'b0);
        base = wr_a.size();
        for (int i = 0; i < 8; i++) send_byte(img_q[i], 1'b0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("midrst_we", 32'(mem_we_o), 32'd0);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("midrst_nwr",   32'(wr_a.size() - base), 32'd1);
        check("midrst_addr0", wr_a[base], BASE_ADDR);
        check("midrst_data0", wr_d[base], words_q[0]);
        run_load(1'b0, "reload");
        do_restart();

        // Restart arriving during the pending write pulse.
        fill_words(2);
        make_image(16'd2, 1'b0);
        base = wr_a.size();
        for (int i = 0; i < 6; i++) send_byte(img_q[i], 1'b0);
        restart_i = 1'b1;
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        check("pend_nwr",  32'(wr_a.size() - base), 32'd1);
        check("pend_addr", wr_a[base], BASE_ADDR);
        check("pend_data", wr_d[base], words_q[0]);
        run_load(1'b0, "pend_reload");
        do_restart();

        // Restart coincident with a DATA byte transfer: byte discarded.
        fill_words(2);
        make_image(16'd2, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(img_q[i], 1'b0);
        byte_valid_i = 1'b1;
        byte_i       = 8'hA5;
        restart_i    = 1'b1;
        @(posedge clk_i);
        #1;
        restart_i    = 1'b0;
        byte_valid_i = 1'b0;
        run_load(1'b0, "rst_xfer");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: largest accepted word count per image.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of the first written word.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 byte_i  input  8  incoming image byte.
REQ-006 byte_valid_i  input  1  byte_i holds a valid byte.
REQ-007 byte_ready_o  output  1  loader can accept a byte; a transfer occurs when byte_valid_i and byte_ready_o are both high at a clock edge.
REQ-008 restart_i  input  1  one-cycle pulse that begins a new load.
REQ-009 mem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr_o  output  32  word-aligned byte address of the write.
REQ-011 mem_wdata_o  output  32  write data.
REQ-012 cpu_hold_o  output  1  holds the CPU in reset while high.
REQ-013 done_o / err_o  output  1 each  load completed / load failed; both are sticky.

Function
REQ-014 Image format: length high byte, length low byte (N words), N words of 4 bytes each sent MSB first, then one checksum byte.
REQ-015 State machine: LEN_HI -> LEN_LO -> DATA -> CKSUM -> DONE. Any state can also go to ERR.
REQ-016 Each state advances only on a byte transfer, except DONE and ERR.
REQ-017 byte_ready_o is 1 in LEN_HI, LEN_LO, DATA and CKSUM, and 0 in DONE and ERR.
REQ-018 In LEN_LO, if N > MAX_WORDS, the next state is ERR.
REQ-019 In LEN_LO, if N = 0, the next state is CKSUM and no memory write occurs.
REQ-020 A 2-bit byte counter wraps 3 -> 0 on each DATA transfer.
REQ-021 When the 4th byte of a word transfers, the registered mem_we_o asserts for exactly one cycle on the following cycle, with the assembled word and its address.
REQ-022 The first write goes to BASE_ADDR; the address increments by 4 per word and is 32-bit modulo.
REQ-023 After word N is written, the state goes to CKSUM.
REQ-024 Checksum = XOR of all length and data bytes. On a match, go to DONE; on a mismatch, go to ERR.
REQ-025 cpu_hold_o is 1 in every state except DONE.
REQ-026 In DONE, done_o is 1. In ERR, err_o is 1 and cpu_hold_o stays 1.
REQ-027 restart_i in any state clears the address, the counters, the checksum, done_o and err_o, and moves the state to LEN_HI on the next edge.
REQ-028 If restart_i and a byte transfer occur in the same cycle, restart wins and the byte is discarded.
REQ-029 byte_valid_i held low stalls the loader indefinitely with no timeout.
REQ-030 A pending mem_we_o pulse still completes if restart_i arrives in the same cycle.

Reset
REQ-031 While rst_i = 0, the state is LEN_HI.
REQ-032 While rst_i = 0: byte_ready_o = 0, mem_we_o = 0, mem_addr_o = BASE_ADDR, mem_wdata_o = 0, cpu_hold_o = 1, done_o = 0, err_o = 0.
REQ-033 byte_ready_o rises on the first clock edge after rst_i deasserts.
REQ-034 Reset asserted mid-load abandons the load, and no partial word is written.

Configuration
REQ-035 Macro IMEM_LOADER_CKSUM_EN: when defined, the CKSUM state and the checksum check are present.
REQ-036 When IMEM_LOADER_CKSUM_EN is undefined, CKSUM is removed and DATA goes directly to DONE after word N (N = 0 goes directly to DONE). The image then carries no checksum byte.

Structure
REQ-037 Shared package imem_loader_pkg holds the state enum, the 16-bit length type and the constant WORD_BYTES = 4.
REQ-038 One sub-module, imem_word_asm, is natural: a shift-in byte-to-word assembler with byte counter and word-ready pulse.
REQ-039 The FSM, address counter and checksum remain in imem_loader.

Verification
REQ-040 Load with N = 2: bytes 00 02 12 34 56 78 9A BC DE F0 plus matching checksum, with MAX_WORDS = 256 and BASE_ADDR = 0. Required: writes 0x12345678 @0 and 0x9ABCDEF0 @4, then done_o = 1 and cpu_hold_o = 0.
REQ-041 Same image with checksum XOR 0x01. Required: err_o = 1, cpu_hold_o = 1, byte_ready_o = 0, and both writes still occurred.
REQ-042 Length 0x0101 with MAX_WORDS = 256. Required: ERR immediately after the 2nd byte, with zero writes.
REQ-043 byte_valid_i toggled randomly every cycle during a 4-word load. Required: identical writes, each mem_we_o exactly one cycle wide.
REQ-044 rst_i pulled low after 6 data bytes, then released and reloaded. Required: no write of the partial word, and the reload writes start at BASE_ADDR.
REQ-045 restart_i coincident with a byte transfer during DATA. Required: the byte is ignored and the next byte is treated as length high.
